// File: rtl/ocx_dlx_xlx_if_core.sv
// GT transceiver bring-up sequencer between the OpenCAPI DLX and the Xilinx GT wizard.
// Sequences GT resets, retries a stuck RX datapath, releases the DLX and qualifies per-lane RX valid.
module ocx_dlx_xlx_if_core #(
    parameter int RESET_HOLD  = 16,
    parameter int RX_TIMEOUT  = 4096,
    parameter int RX_DP_PULSE = 8
) (
    input  logic       clk_156_25MHz,
    input  logic       hb_gtwiz_reset_all_in,
    input  logic       opt_gckn,
    input  logic       ocde,
    output logic       gtwiz_reset_all_out,
    output logic       gtwiz_reset_rx_datapath_out,
    input  logic       gtwiz_reset_tx_done_in,
    input  logic       gtwiz_reset_rx_done_in,
    input  logic       gtwiz_buffbypass_tx_done_in,
    input  logic       gtwiz_buffbypass_rx_done_in,
    input  logic       gtwiz_userclk_tx_active_in,
    input  logic       gtwiz_userclk_rx_active_in,
    output logic       dlx_reset,
    output logic [7:0] io_pb_o0_rx_init_done,
    input  logic [7:0] pb_io_o0_rx_run_lane,
    input  logic       send_first,
    input  logic       ln0_rx_valid_in,
    input  logic       ln1_rx_valid_in,
    input  logic       ln2_rx_valid_in,
    input  logic       ln3_rx_valid_in,
    input  logic       ln4_rx_valid_in,
    input  logic       ln5_rx_valid_in,
    input  logic       ln6_rx_valid_in,
    input  logic       ln7_rx_valid_in,
    output logic       ln0_rx_valid_out,
    output logic       ln1_rx_valid_out,
    output logic       ln2_rx_valid_out,
    output logic       ln3_rx_valid_out,
    output logic       ln4_rx_valid_out,
    output logic       ln5_rx_valid_out,
    output logic       ln6_rx_valid_out,
    output logic       ln7_rx_valid_out
);

    localparam int HW = (RESET_HOLD  > 1) ? $clog2(RESET_HOLD)  : 1;
    localparam int TW = (RX_TIMEOUT  > 1) ? $clog2(RX_TIMEOUT)  : 1;
    localparam int PW = (RX_DP_PULSE > 1) ? $clog2(RX_DP_PULSE) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(RX_TIMEOUT - 1);
    localparam logic [PW-1:0] DP_LAST   = PW'(RX_DP_PULSE - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_TX   = 3'd1,
        ST_WAIT_RX   = 3'd2,
        ST_RX_DP_RST = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   rx_timer;
    logic [PW-1:0]   dp_cnt;
    logic            ocde_meta;
    logic            ocde_sync;
    logic            tx_ok;
    logic            rx_ok;
    logic [7:0]      valid_in;
    logic [7:0]      valid_q;
    logic            unused_gckn;

    assign unused_gckn = opt_gckn;

    assign tx_ok = gtwiz_reset_tx_done_in & gtwiz_buffbypass_tx_done_in & gtwiz_userclk_tx_active_in;
    assign rx_ok = gtwiz_reset_rx_done_in & gtwiz_buffbypass_rx_done_in & gtwiz_userclk_rx_active_in;

    assign valid_in = {ln7_rx_valid_in, ln6_rx_valid_in, ln5_rx_valid_in, ln4_rx_valid_in,
                       ln3_rx_valid_in, ln2_rx_valid_in, ln1_rx_valid_in, ln0_rx_valid_in};

    // Card reset synchronizer; left unreset so a card already up is seen right after hb reset.
    always_ff @(posedge clk_156_25MHz) begin
        ocde_meta <= ocde;
        ocde_sync <= ocde_meta;
    end

    // Next-state decode; ocde beats link drop, which beats timeout, which beats rx_ok.
    always_comb begin
        state_nx = state;
        if (!ocde_sync) begin
            state_nx = ST_RESET;
        end else begin
            case (state)
                ST_RESET: begin
                    if (hold_cnt == HOLD_LAST) state_nx = ST_WAIT_TX;
                    else                       state_nx = ST_RESET;
                end
                ST_WAIT_TX: begin
                    if (tx_ok) state_nx = ST_WAIT_RX;
                    else       state_nx = ST_WAIT_TX;
                end
                ST_WAIT_RX: begin
                    if (rx_timer == TO_LAST) state_nx = ST_RX_DP_RST;
                    else if (rx_ok)          state_nx = ST_RUN;
                    else                     state_nx = ST_WAIT_RX;
                end
                ST_RX_DP_RST: begin
                    if (dp_cnt == DP_LAST) state_nx = ST_WAIT_RX;
                    else                   state_nx = ST_RX_DP_RST;
                end
                ST_RUN: begin
                    if (!(tx_ok && rx_ok)) state_nx = ST_RESET;
                    else                   state_nx = ST_RUN;
                end
                default: state_nx = ST_RESET;
            endcase
        end
    end

    // State register, dwell counters and outputs decoded from the state being entered.
    always_ff @(posedge clk_156_25MHz or posedge hb_gtwiz_reset_all_in) begin
        if (hb_gtwiz_reset_all_in) begin
            state                       <= ST_RESET;
            hold_cnt                    <= {HW{1'b0}};
            rx_timer                    <= {TW{1'b0}};
            dp_cnt                      <= {PW{1'b0}};
            gtwiz_reset_all_out         <= 1'b1;
            gtwiz_reset_rx_datapath_out <= 1'b0;
            dlx_reset                   <= 1'b1;
            io_pb_o0_rx_init_done       <= 8'h00;
            valid_q                     <= 8'h00;
        end else begin
            state    <= state_nx;
            hold_cnt <= (state == ST_RESET && state_nx == ST_RESET && ocde_sync)
                        ? hold_cnt + HW'(1) : {HW{1'b0}};
            rx_timer <= (state == ST_WAIT_RX && state_nx == ST_WAIT_RX)
                        ? rx_timer + TW'(1) : {TW{1'b0}};
            dp_cnt   <= (state == ST_RX_DP_RST && state_nx == ST_RX_DP_RST)
                        ? dp_cnt + PW'(1) : {PW{1'b0}};
            gtwiz_reset_all_out         <= (state_nx == ST_RESET);
            gtwiz_reset_rx_datapath_out <= (state_nx == ST_RX_DP_RST);
            dlx_reset <= !((state_nx == ST_RUN) ||
                           (send_first && (state_nx == ST_WAIT_RX || state_nx == ST_RX_DP_RST)));
            // Lanes qualify one cycle after RUN is entered and drop on the edge RUN is left.
            io_pb_o0_rx_init_done <= (state == ST_RUN && state_nx == ST_RUN)
                                     ? pb_io_o0_rx_run_lane : 8'h00;
            valid_q <= valid_in & io_pb_o0_rx_init_done;
        end
    end

    assign ln0_rx_valid_out = valid_q[0];
    assign ln1_rx_valid_out = valid_q[1];
    assign ln2_rx_valid_out = valid_q[2];
    assign ln3_rx_valid_out = valid_q[3];
    assign ln4_rx_valid_out = valid_q[4];
    assign ln5_rx_valid_out = valid_q[5];
    assign ln6_rx_valid_out = valid_q[6];
    assign ln7_rx_valid_out = valid_q[7];

endmodule

// File: tb/tb_ocx_dlx_xlx_if_core.sv
// Bench for ocx_dlx_xlx_if_core: directed scenarios plus random stimulus against
// a phase/age reference model of the bring-up sequence.
module tb_ocx_dlx_xlx_if_core;

    localparam int RESET_HOLD  = 16;
    localparam int RX_TIMEOUT  = 32;
    localparam int RX_DP_PULSE = 8;

    localparam int P_RESET = 0, P_WTX = 1, P_WRX = 2, P_DP = 3, P_RUN = 4;
    localparam logic [18:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 8'h00, 8'h00};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       opt_gckn = 1'b0;
    logic       ocde = 1'b1;
    logic       tx_done = 1'b1, rx_done = 1'b1, bb_tx = 1'b1, bb_rx = 1'b1, uc_tx = 1'b1, uc_rx = 1'b1;
    logic [7:0] run_lane = 8'hFF;
    logic       send_first = 1'b0;
    logic [7:0] vin = 8'h00;

    logic       all_out, dp_out, dlx_reset;
    logic [7:0] init_done;
    logic       v0, v1, v2, v3, v4, v5, v6, v7;
    logic [7:0] vout;
    assign vout = {v7, v6, v5, v4, v3, v2, v1, v0};

    int passed = 0;
    int total  = 0;

    // reference model state
    int         m_phase;
    int         m_age;
    logic       m_s1 = 1'b1, m_s2 = 1'b1;
    logic       m_all, m_dp, m_dlx;
    logic [7:0] m_init, m_valid;

    always #5 clk = ~clk;

    ocx_dlx_xlx_if_core #(.RESET_HOLD(RESET_HOLD), .RX_TIMEOUT(RX_TIMEOUT), .RX_DP_PULSE(RX_DP_PULSE)) dut (
        .clk_156_25MHz(clk), .hb_gtwiz_reset_all_in(rst), .opt_gckn(opt_gckn), .ocde(ocde),
        .gtwiz_reset_all_out(all_out), .gtwiz_reset_rx_datapath_out(dp_out),
        .gtwiz_reset_tx_done_in(tx_done), .gtwiz_reset_rx_done_in(rx_done),
        .gtwiz_buffbypass_tx_done_in(bb_tx), .gtwiz_buffbypass_rx_done_in(bb_rx),
        .gtwiz_userclk_tx_active_in(uc_tx), .gtwiz_userclk_rx_active_in(uc_rx),
        .dlx_reset(dlx_reset), .io_pb_o0_rx_init_done(init_done), .pb_io_o0_rx_run_lane(run_lane),
        .send_first(send_first),
        .ln0_rx_valid_in(vin[0]), .ln1_rx_valid_in(vin[1]), .ln2_rx_valid_in(vin[2]), .ln3_rx_valid_in(vin[3]),
        .ln4_rx_valid_in(vin[4]), .ln5_rx_valid_in(vin[5]), .ln6_rx_valid_in(vin[6]), .ln7_rx_valid_in(vin[7]),
        .ln0_rx_valid_out(v0), .ln1_rx_valid_out(v1), .ln2_rx_valid_out(v2), .ln3_rx_valid_out(v3),
        .ln4_rx_valid_out(v4), .ln5_rx_valid_out(v5), .ln6_rx_valid_out(v6), .ln7_rx_valid_out(v7)
    );

    function automatic logic [18:0] dut_vec();
        return {all_out, dp_out, dlx_reset, init_done, vout};
    endfunction

    function automatic logic [18:0] model_vec();
        return {m_all, m_dp, m_dlx, m_init, m_valid};
    endfunction

    task automatic model_reset();
        m_phase = P_RESET; m_age = 0;
        m_all = 1'b1; m_dp = 1'b0; m_dlx = 1'b1; m_init = 8'h00; m_valid = 8'h00;
    endtask

    // One clock edge of the specified behaviour: which phase we are in and how long we have been there.
    task automatic model_step();
        logic sync_used, txok, rxok;
        int np;
        if (rst) begin
            m_s2 = m_s1; m_s1 = ocde;
            model_reset();
            return;
        end
        txok = tx_done & bb_tx & uc_tx;
        rxok = rx_done & bb_rx & uc_rx;
        sync_used = m_s2; m_s2 = m_s1; m_s1 = ocde;
        np = m_phase;
        if (!sync_used) np = P_RESET;
        else if (m_phase == P_RESET) np = (m_age == RESET_HOLD - 1) ? P_WTX : P_RESET;
        else if (m_phase == P_WTX)   np = txok ? P_WRX : P_WTX;
        else if (m_phase == P_WRX)   np = (m_age == RX_TIMEOUT - 1) ? P_DP : (rxok ? P_RUN : P_WRX);
        else if (m_phase == P_DP)    np = (m_age == RX_DP_PULSE - 1) ? P_WRX : P_DP;
        else                         np = (txok && rxok) ? P_RUN : P_RESET;
        m_valid = vin & m_init;
        m_init  = (m_phase == P_RUN && np == P_RUN) ? run_lane : 8'h00;
        m_age   = (np != m_phase || !sync_used) ? 0 : m_age + 1;
        m_phase = np;
        m_all = (np == P_RESET);
        m_dp  = (np == P_DP);
        m_dlx = !(np == P_RUN || (send_first && (np == P_WRX || np == P_DP)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (5) tick();
        total++;
        if (dut_vec() !== RESET_VEC) $display("FAIL reset_values got=%h exp=%h", dut_vec(), RESET_VEC);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_bringup();
        int cnt = -1;
        for (int i = 0; i < 100; i++) begin
            vin = 8'($urandom);
            tick();
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL bringup_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passed++;
            if (!all_out) begin cnt = i + 1; break; end
        end
        total++;
        if (cnt != RESET_HOLD) $display("FAIL bringup_hold got=%0d exp=%0d", cnt, RESET_HOLD);
        else passed++;
        repeat (3) tick();
        total++;
        if ({dlx_reset, init_done} !== {1'b0, 8'hFF}) $display("FAIL bringup_run got=%b/%h exp=0/ff", dlx_reset, init_done);
        else passed++;
        vin = 8'hA5;
        tick();
        total++;
        if (vout !== 8'hA5) $display("FAIL bringup_valid got=%h exp=a5", vout);
        else passed++;
    endtask

    task automatic test_rx_retry();
        int last_rise = -1, rise_at = -1, pulses = 0;
        logic prev = 1'b0;
        rx_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            vin = 8'($urandom);
            tick();
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL retry_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passed++;
            if (dp_out && !prev) begin
                if (last_rise >= 0) begin
                    total++;
                    if (i - last_rise != RX_TIMEOUT + RX_DP_PULSE)
                        $display("FAIL retry_period got=%0d exp=%0d", i - last_rise, RX_TIMEOUT + RX_DP_PULSE);
                    else passed++;
                end
                last_rise = i; rise_at = i;
            end
            if (!dp_out && prev) begin
                pulses++;
                total++;
                if (i - rise_at != RX_DP_PULSE) $display("FAIL retry_width got=%0d exp=%0d", i - rise_at, RX_DP_PULSE);
                else passed++;
            end
            prev = dp_out;
        end
        total++;
        if (pulses < 3) $display("FAIL retry_count got=%0d exp>=3", pulses);
        else passed++;
        rx_done = 1'b1;
        for (int i = 0; i < 60 && dlx_reset; i++) tick();
        tick();
        total++;
        if ({dlx_reset, init_done} !== {1'b0, 8'hFF}) $display("FAIL retry_run got=%b/%h exp=0/ff", dlx_reset, init_done);
        else passed++;
    endtask

    task automatic test_send_first();
        send_first = 1'b1;
        rx_done = 1'b0;
        tick();
        for (int i = 0; i < 60 && all_out; i++) tick();
        tick();
        total++;
        if ({all_out, dlx_reset, init_done} !== {1'b0, 1'b0, 8'h00})
            $display("FAIL send_first got=%b/%b/%h exp=0/0/00", all_out, dlx_reset, init_done);
        else passed++;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL send_first_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passed++;
        end
        send_first = 1'b0;
        rx_done = 1'b1;
        for (int i = 0; i < 20 && dlx_reset; i++) tick();
        tick();
    endtask

    task automatic test_partial_lanes();
        run_lane = 8'h0F;
        vin = 8'hFF;
        tick(); tick();
        total++;
        if ({init_done, vout} !== {8'h0F, 8'h0F}) $display("FAIL partial_lanes got=%h/%h exp=0f/0f", init_done, vout);
        else passed++;
    endtask

    task automatic test_ocde_drop();
        ocde = 1'b0;
        repeat (3) tick();
        total++;
        if ({all_out, dlx_reset, init_done} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL ocde_drop got=%b/%b/%h exp=1/1/00", all_out, dlx_reset, init_done);
        else passed++;
        tick();
        total++;
        if (vout !== 8'h00) $display("FAIL ocde_valid got=%h exp=00", vout);
        else passed++;
        ocde = 1'b1;
        run_lane = 8'hFF;
        for (int i = 0; i < 100 && dlx_reset; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL ocde_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passed++;
        end
        total++;
        if (dlx_reset !== 1'b0) $display("FAIL ocde_recover got=%b exp=0", dlx_reset);
        else passed++;
        tick();
    endtask

    task automatic test_link_loss();
        int cnt = -1;
        uc_rx = 1'b0;
        tick();
        uc_rx = 1'b1;
        total++;
        if ({all_out, dlx_reset, init_done} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL link_loss got=%b/%b/%h exp=1/1/00", all_out, dlx_reset, init_done);
        else passed++;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!all_out) begin cnt = i + 1; break; end
        end
        total++;
        if (cnt != RESET_HOLD) $display("FAIL link_loss_hold got=%0d exp=%0d", cnt, RESET_HOLD);
        else passed++;
        repeat (3) tick();
        total++;
        if (dut_vec() !== model_vec() || dlx_reset !== 1'b0) $display("FAIL link_loss_run got=%h exp=%h", dut_vec(), model_vec());
        else passed++;
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== RESET_VEC) $display("FAIL async_reset got=%h exp=%h", dut_vec(), RESET_VEC);
        else passed++;
        @(posedge clk); model_step(); #1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] flags;
        for (int i = 0; i < 3000; i++) begin
            flags = ($urandom_range(0, 24) == 0) ? 6'($urandom) : 6'h3F;
            if (i >= 1500 && i < 1700) flags[1] = 1'b0;
            {uc_rx, uc_tx, bb_rx, bb_tx, rx_done, tx_done} = flags;
            ocde       = ($urandom_range(0, 199) != 0);
            send_first = 1'($urandom);
            run_lane   = 8'($urandom);
            vin        = 8'($urandom);
            tick();
            total++;
            if (dut_vec() !== model_vec()) $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_rx_retry();
        test_send_first();
        test_partial_lanes();
        test_ocde_drop();
        test_link_loss();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
